gshare_ctrl: RTL and testbench
==============================

Name: gshare_ctrl

Overview:
- Controller that sequences the 1024-entry 2-bit pattern history table (PHT) for the fetch-stage gshare branch predictor.
- Initialises every PHT entry after reset and forms the lookup index from the PC and the global history.
- Tracks in-flight predictions in order and computes saturating-counter updates on resolution.
- Repairs global history on a mispredict. Sits between fetch, the branch-resolve stage and the PHT.

Parameters:
- IDX_W, 10, PHT index width; PHT holds 2**IDX_W entries.
- DEPTH, 8, in-flight prediction FIFO entries (power of 2).

Ports:
- clk  in  1  sole clock; all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- lookup_valid  in  1  fetch presents a branch PC.
- lookup_pc  in  16  branch PC.
- lookup_ready  out  1  controller can accept a lookup.
- pred_taken  out  1  combinational prediction for the current lookup_pc.
- resolve_valid  in  1  oldest in-flight branch resolved.
- resolve_taken  in  1  actual outcome.
- mispredict  out  1  combinational; resolve outcome differs from the stored prediction.
- pht_index  out  IDX_W  PHT read index.
- pht_prediction  in  2  PHT counter at pht_index (combinational read).
- pht_update  out  1  PHT write enable (PHT writes on negedge).
- pht_updated_index  out  IDX_W  PHT write index.
- pht_updated_counter  out  2  PHT write data.

Behaviour:
- Reset (async, rst_n=0) clears everything:
  - State=INIT, init counter=0, GHR=0, FIFO empty.
  - pht_update=0, pht_updated_index=0, pht_updated_counter=2'b01, lookup_ready=0.
  - Reset asserted mid-operation discards all FIFO contents and restarts INIT.
- INIT:
  - Each cycle registers pht_update=1, pht_updated_index=init counter, pht_updated_counter=2'b01, then increments the counter.
  - After index 2**IDX_W-1 is written, the next state is RUN. Sweep = 1024 cycles; first RUN cycle is cycle 1025 after reset release.
  - lookup_ready=0 and resolve_valid is ignored throughout INIT.
- Index (combinational): pht_index = lookup_pc[IDX_W:1] XOR GHR.
- Forwarding: effective counter = pht_updated_counter if pht_update && pht_updated_index==pht_index, else pht_prediction.
- pred_taken = effective counter bit 1. Valid whenever lookup_valid, including in INIT; it is meaningful only when accepted.
- lookup_ready = (state==RUN) && FIFO not full. Accepted lookup = lookup_valid && lookup_ready.
- On an accepted lookup:
  - Enqueue {index, effective counter, GHR snapshot, pred_taken}.
  - GHR <= {GHR[IDX_W-2:0], pred_taken} (speculative).
- Resolve (RUN, resolve_valid, FIFO not empty) always consumes the head entry:
  - New counter = stored counter +1 if taken (saturate at 2'b11), -1 if not taken (saturate at 2'b00).
  - Registered next cycle: pht_update=1, pht_updated_index=head index, pht_updated_counter=new counter. One-cycle pulse.
  - Update uses the counter stored at lookup time; the PHT is not re-read.
- resolve_valid with FIFO empty: ignored, no update, mispredict=0.
- mispredict = resolve accepted && resolve_taken != head pred_taken. On a mispredict:
  - FIFO cleared (head and all younger entries).
  - GHR <= {head GHR snapshot[IDX_W-2:0], resolve_taken}.
  - A lookup accepted in the same cycle is dropped: not enqueued, no GHR shift. Fetch redirects anyway.
- Lookup + correct resolve in the same cycle: both take effect. FIFO count unchanged; GHR shifts by the lookup only.
- pht_update is 0 in any RUN cycle not following an accepted resolve.
- FIFO pointers wrap modulo DEPTH; a count register distinguishes full from empty.

Test Plan:
- Init sweep:
  - Release rst_n, hold lookup_valid=1.
  - Required: pht_update=1 for exactly 1024 consecutive cycles, indices 0..1023 in order, data 2'b01.
  - lookup_ready=0 throughout; lookup_ready=1 on cycle 1025.
- Train and mispredict:
  - Setup: GHR=0, lookup_pc=0x0040, PHT model=01.
  - Step 1 (lookup): pht_index=0x020, pred_taken=0.
  - Step 2 (resolve_taken=1): mispredict=1; next cycle pht_update=1, index 0x020, counter 2'b10; GHR=0x001.
- Forwarding:
  - Resolve the taken branch at index 0x020 (stored counter 2'b10).
  - In the following cycle present a lookup hashing to 0x020 while the PHT model still returns 01.
  - Required: pred_taken=1 (forwarded 2'b11).
- Backpressure:
  - 8 lookups with no resolves -> lookup_ready=0 on the 9th.
  - One correct resolve -> lookup_ready=1 the next cycle.
  - Simultaneous lookup+resolve when count=8 is not accepted.
- Flush:
  - 3 lookups predicted not-taken (GHR after = 0x000), then the first resolves taken.
  - Required: mispredict=1, FIFO empty next cycle, GHR=0x001.
  - Subsequent resolve_valid is ignored (no pht_update).
- Reset mid-operation:
  - Assert rst_n=0 at init index 500, release.
  - Required: pht_update deasserts asynchronously; sweep restarts at index 0.

Source files
------------

// File: rtl/gshare_ctrl.sv
// gshare_ctrl
// Sequencing controller for a gshare branch predictor's pattern history
// table (PHT) of 2**IDX_W two-bit saturating counters.
//
// After reset it sweeps every PHT entry to weakly-not-taken (2'b01). It then
// enters RUN, where it does the following:
//   - hashes the fetch PC with the global history register (GHR) to form the
//     PHT read index;
//   - forwards a same-index PHT write into the prediction;
//   - tracks accepted predictions in an in-order FIFO;
//   - on resolution, produces the saturating counter update from the counter
//     captured at lookup time;
//   - on a mispredict, flushes the FIFO and repairs the GHR.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   lookup_valid/pc/ready fetch lookup handshake (PC is 16 bits)
//   pred_taken            combinational prediction for lookup_pc
//   resolve_valid/taken   outcome of the oldest in-flight branch
//   mispredict            combinational; outcome differs from prediction
//   pht_index             PHT read index
//   pht_prediction        PHT counter at pht_index (combinational read)
//   pht_update            PHT write enable (PHT writes on negedge)
//   pht_updated_index     PHT write index
//   pht_updated_counter   PHT write data
module gshare_ctrl #(
  parameter int IDX_W = 10,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             lookup_valid,
  input  logic [15:0]      lookup_pc,
  output logic             lookup_ready,
  output logic             pred_taken,
  input  logic             resolve_valid,
  input  logic             resolve_taken,
  output logic             mispredict,
  output logic [IDX_W-1:0] pht_index,
  input  logic [1:0]       pht_prediction,
  output logic             pht_update,
  output logic [IDX_W-1:0] pht_updated_index,
  output logic [1:0]       pht_updated_counter
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [IDX_W-1:0] LAST_IDX = {IDX_W{1'b1}};

  logic [0:0]       state;
  logic [IDX_W-1:0] init_cnt;
  logic [IDX_W-1:0] ghr;

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  // FIFO storage holds no reset state; count/pointers define validity.
  logic [IDX_W-1:0] fifo_idx  [DEPTH];
  logic [1:0]       fifo_ctr  [DEPTH];
  logic [IDX_W-1:0] fifo_ghr  [DEPTH];
  logic             fifo_pred [DEPTH];

  logic [1:0]       eff_ctr;
  logic             fifo_full;
  logic             fifo_empty;
  logic             lookup_acc;
  logic             resolve_acc;
  logic             enq;
  logic [1:0]       head_ctr;
  logic [1:0]       new_ctr;

  // Only PC bits [IDX_W:1] take part in the hash.
  logic unused_pc;
  assign unused_pc = ^{lookup_pc[15:IDX_W+1], lookup_pc[0]};

  assign pht_index = lookup_pc[IDX_W:1] ^ ghr;

  // A write landing on the index being read this cycle has not reached the
  // PHT array yet (it writes on negedge), so bypass it into the prediction.
  assign eff_ctr = (pht_update && (pht_updated_index == pht_index)) ?
                   pht_updated_counter : pht_prediction;
  assign pred_taken = eff_ctr[1];

  assign fifo_full    = (count == CNT_W'(DEPTH));
  assign fifo_empty   = (count == '0);
  assign lookup_ready = (state == ST_RUN) && !fifo_full;
  assign lookup_acc   = lookup_valid && lookup_ready;
  assign resolve_acc  = (state == ST_RUN) && resolve_valid && !fifo_empty;
  assign mispredict   = resolve_acc && (resolve_taken != fifo_pred[rd_ptr]);

  // A lookup arriving alongside a mispredict is on the wrong path; drop it.
  assign enq = lookup_acc && !mispredict;

  assign head_ctr = fifo_ctr[rd_ptr];

  // Two-bit saturating counter step based on the counter seen at lookup.
  always_comb begin
    new_ctr = head_ctr;
    if (resolve_taken) begin
      if (head_ctr != 2'b11) new_ctr = head_ctr + 2'b01;
    end else begin
      if (head_ctr != 2'b00) new_ctr = head_ctr - 2'b01;
    end
  end

  // Entry payload capture; validity is tracked by the control block below.
  always_ff @(posedge clk) begin
    if (enq) begin
      fifo_idx[wr_ptr]  <= pht_index;
      fifo_ctr[wr_ptr]  <= eff_ctr;
      fifo_ghr[wr_ptr]  <= ghr;
      fifo_pred[wr_ptr] <= pred_taken;
    end
  end

  // Control: init sweep, then RUN with FIFO bookkeeping, GHR speculation and
  // repair, and the one-cycle PHT update pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state               <= ST_INIT;
      init_cnt            <= '0;
      ghr                 <= '0;
      wr_ptr              <= '0;
      rd_ptr              <= '0;
      count               <= '0;
      pht_update          <= 1'b0;
      pht_updated_index   <= '0;
      pht_updated_counter <= 2'b01;
    end else if (state == ST_INIT) begin
      pht_update          <= 1'b1;
      pht_updated_index   <= init_cnt;
      pht_updated_counter <= 2'b01;
      init_cnt            <= init_cnt + IDX_W'(1);
      if (init_cnt == LAST_IDX) state <= ST_RUN;
    end else begin
      pht_update <= resolve_acc;
      if (resolve_acc) begin
        pht_updated_index   <= fifo_idx[rd_ptr];
        pht_updated_counter <= new_ctr;
      end

      if (mispredict) begin
        // Everything younger than the head was fetched down the wrong path.
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
        ghr    <= {fifo_ghr[rd_ptr][IDX_W-2:0], resolve_taken};
      end else begin
        if (enq) begin
          wr_ptr <= wr_ptr + PTR_W'(1);
          ghr    <= {ghr[IDX_W-2:0], pred_taken};
        end
        if (resolve_acc) rd_ptr <= rd_ptr + PTR_W'(1);
        if (enq && !resolve_acc)      count <= count + CNT_W'(1);
        else if (!enq && resolve_acc) count <= count - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_gshare_ctrl.sv
// tb_gshare_ctrl
// Directed-vector scoreboard bench for gshare_ctrl. Stimulus tasks push the
// expected lookup, resolve and PHT-update responses into queues; a negedge
// monitor pops and compares whenever the DUT presents the matching output.
module tb_gshare_ctrl;

  typedef struct {
    logic [9:0] idx;
    logic [1:0] ctr;
  } upd_t;

  typedef struct {
    logic [9:0] idx;
    logic       pred;
  } lk_t;

  logic        clk;
  logic        rst_n;
  logic        lookup_valid;
  logic [15:0] lookup_pc;
  logic        lookup_ready;
  logic        pred_taken;
  logic        resolve_valid;
  logic        resolve_taken;
  logic        mispredict;
  logic [9:0]  pht_index;
  logic [1:0]  pht_prediction;
  logic        pht_update;
  logic [9:0]  pht_updated_index;
  logic [1:0]  pht_updated_counter;

  int tests;
  int failures;

  upd_t upd_q[$];
  lk_t  lk_q[$];
  logic rs_q[$];

  logic [9:0] bp_idx [8] = '{10'h007, 10'h00E, 10'h01C, 10'h038,
                             10'h070, 10'h0E0, 10'h1C0, 10'h380};

  gshare_ctrl #(.IDX_W(10), .DEPTH(8)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .lookup_valid        (lookup_valid),
    .lookup_pc           (lookup_pc),
    .lookup_ready        (lookup_ready),
    .pred_taken          (pred_taken),
    .resolve_valid       (resolve_valid),
    .resolve_taken       (resolve_taken),
    .mispredict          (mispredict),
    .pht_index           (pht_index),
    .pht_prediction      (pht_prediction),
    .pht_update          (pht_update),
    .pht_updated_index   (pht_updated_index),
    .pht_updated_counter (pht_updated_counter)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic expUpdate(input logic [9:0] idx, input logic [1:0] ctr);
    upd_t u;
    u.idx = idx;
    u.ctr = ctr;
    upd_q.push_back(u);
  endtask

  task automatic expLookup(input logic [9:0] idx, input logic pred);
    lk_t l;
    l.idx  = idx;
    l.pred = pred;
    lk_q.push_back(l);
  endtask

  task automatic expResolve(input logic mp);
    rs_q.push_back(mp);
  endtask

  // Drive one cycle of inputs, then step to just after the next posedge.
  task automatic applyStimulus(input logic lv, input logic [15:0] pc,
                               input logic [1:0] pp, input logic rv,
                               input logic rt);
    lookup_valid   = lv;
    lookup_pc      = pc;
    pht_prediction = pp;
    resolve_valid  = rv;
    resolve_taken  = rt;
    @(posedge clk);
    #1;
  endtask

  // Release reset and run the init sweep; a nonzero stop_at returns right
  // after that posedge so the caller can interrupt the sweep.
  task automatic initSweep(input int stop_at);
    int ready_seen;
    ready_seen = 0;
    for (int i = 0; i < 1024; i++) expUpdate(i[9:0], 2'b01);
    rst_n        = 1'b1;
    lookup_valid = 1'b1;
    lookup_pc    = 16'h0000;
    for (int k = 1; k <= 1023; k++) begin
      @(posedge clk);
      #1;
      if (lookup_ready) ready_seen++;
      if (k == stop_at) return;
    end
    lookup_valid = 1'b0;
    checkOutput("ready_during_init", ready_seen, 0);
    @(posedge clk);
    #1;
    checkOutput("ready_after_init", lookup_ready, 1);
  endtask

  task automatic checkResetState();
    checkOutput("rst_pht_update", pht_update, 0);
    checkOutput("rst_updated_index", pht_updated_index, 0);
    checkOutput("rst_updated_counter", pht_updated_counter, 2'b01);
    checkOutput("rst_lookup_ready", lookup_ready, 0);
  endtask

  // Monitor: compare each presented response against the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (lookup_valid && lookup_ready) begin
        if (lk_q.size() == 0) begin
          checkOutput("unexpected_lookup", 1, 0);
        end else begin
          lk_t l;
          l = lk_q.pop_front();
          checkOutput("lookup_index", pht_index, l.idx);
          checkOutput("lookup_pred", pred_taken, l.pred);
        end
      end
      if (resolve_valid) begin
        if (rs_q.size() == 0) begin
          checkOutput("unexpected_resolve", 1, 0);
        end else begin
          logic mp;
          mp = rs_q.pop_front();
          checkOutput("mispredict", mispredict, mp);
        end
      end
      if (pht_update) begin
        if (upd_q.size() == 0) begin
          checkOutput("unexpected_update", pht_update, 0);
        end else begin
          upd_t u;
          u = upd_q.pop_front();
          checkOutput("update_index", pht_updated_index, u.idx);
          checkOutput("update_counter", pht_updated_counter, u.ctr);
        end
      end
    end
  end

  initial begin
    tests          = 0;
    failures       = 0;
    rst_n          = 1'b1;
    lookup_valid   = 1'b0;
    lookup_pc      = 16'h0000;
    resolve_valid  = 1'b0;
    resolve_taken  = 1'b0;
    pht_prediction = 2'b01;

    // Power-on reset and a full sweep.
    #2 rst_n = 1'b0;
    #2 checkResetState();
    @(posedge clk);
    #1;
    initSweep(0);

    // Flush: three not-taken lookups, oldest resolves taken. A lookup in the
    // mispredict cycle is dropped, so the later resolves find an empty FIFO.
    expLookup(10'h008, 1'b0);
    applyStimulus(1, 16'h0010, 2'b01, 0, 0);
    expLookup(10'h010, 1'b0);
    applyStimulus(1, 16'h0020, 2'b01, 0, 0);
    expLookup(10'h018, 1'b0);
    applyStimulus(1, 16'h0030, 2'b01, 0, 0);
    expLookup(10'h020, 1'b0);
    expResolve(1'b1);
    expUpdate(10'h008, 2'b10);
    applyStimulus(1, 16'h0040, 2'b01, 1, 1);
    expResolve(1'b0);
    applyStimulus(0, 16'h0000, 2'b01, 1, 1);
    expResolve(1'b0);
    applyStimulus(0, 16'h0000, 2'b01, 1, 0);
    // Repaired GHR of 0x001 shows up in the hash.
    expLookup(10'h001, 1'b0);
    applyStimulus(1, 16'h0000, 2'b00, 0, 0);
    applyStimulus(0, 16'h0000, 2'b01, 0, 0);

    // Reset with an entry in flight, then interrupt the sweep at index 500.
    rst_n = 1'b0;
    #1 checkResetState();
    upd_q.delete();
    @(posedge clk);
    #1;
    initSweep(501);
    checkOutput("sweep_index_at_interrupt", pht_updated_index, 500);
    #1 rst_n = 1'b0;
    #1 checkResetState();
    upd_q.delete();
    @(posedge clk);
    #1;
    initSweep(0);

    // Train and mispredict from GHR=0.
    expLookup(10'h020, 1'b0);
    applyStimulus(1, 16'h0040, 2'b01, 0, 0);
    expResolve(1'b1);
    expUpdate(10'h020, 2'b10);
    applyStimulus(0, 16'h0000, 2'b01, 1, 1);

    // Forwarding: GHR=1, PC 0x0042 hashes to 0x020; pending write of 10 wins.
    expLookup(10'h020, 1'b1);
    applyStimulus(1, 16'h0042, 2'b01, 0, 0);
    expResolve(1'b0);
    expUpdate(10'h020, 2'b11);
    applyStimulus(0, 16'h0000, 2'b01, 1, 1);
    // GHR=3, PC 0x0046 hashes to 0x020; forwarded 11 despite PHT reading 01.
    expLookup(10'h020, 1'b1);
    applyStimulus(1, 16'h0046, 2'b01, 0, 0);
    // Taken resolve on a saturated counter stays at 11.
    expResolve(1'b0);
    expUpdate(10'h020, 2'b11);
    applyStimulus(0, 16'h0000, 2'b01, 1, 1);

    // Backpressure: GHR starts at 0x007, eight not-taken lookups fill FIFO.
    for (int i = 0; i < 8; i++) begin
      expLookup(bp_idx[i], 1'b0);
      applyStimulus(1, 16'h0000, 2'b00, 0, 0);
    end
    checkOutput("ready_when_full", lookup_ready, 0);
    // Lookup with resolve while full: only the resolve is taken.
    expResolve(1'b0);
    expUpdate(10'h007, 2'b00);
    applyStimulus(1, 16'h0000, 2'b00, 1, 0);
    checkOutput("ready_after_resolve", lookup_ready, 1);
    // Lookup plus correct resolve keeps count at 7; one more lookup fills it.
    expLookup(10'h300, 1'b0);
    expResolve(1'b0);
    expUpdate(10'h00E, 2'b00);
    applyStimulus(1, 16'h0000, 2'b00, 1, 0);
    checkOutput("ready_count_seven", lookup_ready, 1);
    expLookup(10'h200, 1'b0);
    applyStimulus(1, 16'h0000, 2'b00, 0, 0);
    checkOutput("ready_full_again", lookup_ready, 0);

    applyStimulus(0, 16'h0000, 2'b01, 0, 0);
    applyStimulus(0, 16'h0000, 2'b01, 0, 0);
    applyStimulus(0, 16'h0000, 2'b01, 0, 0);
    checkOutput("pending_updates", upd_q.size(), 0);
    checkOutput("pending_lookups", lk_q.size(), 0);
    checkOutput("pending_resolves", rs_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
